// File: rtl/canvas_pkg.sv
// rtl/canvas_pkg.sv - shared canvas types, constants and helpers
// Purpose: scheduler state encoding, default brush limit, coordinate width and
//          the brush-size clamp used when a stamp is accepted.
// Ports:   none (package).
package canvas_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STAMP = 2'd1,
        CLEAR = 2'd2
    } sched_state_t;

    localparam int MAX_BRUSH_DEFAULT = 8;
    localparam int COORD_W           = 10;

    function automatic logic [3:0] clampSize(input logic [3:0] size, input int maxBrush);
        if (int'(size) > maxBrush) begin
            return 4'(maxBrush);
        end
        return size;
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// rtl/rect_scanner.sv - dx/dy raster counter shared by stamp and clear scans
// Purpose: walks a spanX x spanY rectangle in raster order (dx inner, dy outer).
//          load restarts at (0,0) and captures the spans; advance steps to the
//          next position; last flags the final position of the rectangle.
// Ports:   clk, rst (async active-low), load, advance, spanX/spanY (rectangle
//          size), nextDx/nextDy (position after the current one), last.
module rect_scanner #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    input  logic [CW-1:0] spanX,
    input  logic [CW-1:0] spanY,
    output logic [CW-1:0] nextDx,
    output logic [CW-1:0] nextDy,
    output logic          last
);

    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic [CW-1:0] spanXq;
    logic [CW-1:0] spanYq;
    logic          endOfRow;

    assign endOfRow = (dx == spanXq - CW'(1));
    assign nextDx   = endOfRow ? '0 : dx + CW'(1);
    assign nextDy   = endOfRow ? dy + CW'(1) : dy;
    assign last     = endOfRow && (dy == spanYq - CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dx     <= '0;
            dy     <= '0;
            spanXq <= '0;
            spanYq <= '0;
        end else if (load) begin
            dx     <= '0;
            dy     <= '0;
            spanXq <= spanX;
            spanYq <= spanY;
        end else if (advance) begin
            dx <= nextDx;
            dy <= nextDy;
        end
    end

endmodule

// File: rtl/canvas_write_scheduler.sv
// rtl/canvas_write_scheduler.sv - turns brush stamps and canvas clears into framebuffer writes
// Purpose: one registered framebuffer write per cycle. A stamp paints a square of
//          up to MAX_BRUSH pixels; a clear scans the whole canvas with color 0 and
//          has priority over stamps.
// Ports:   clk, rst (async active-low); clear_req (level); stamp_valid/stamp_ready
//          handshake with stamp_x, stamp_y, stamp_size, stamp_color; write_x,
//          write_y, write_en, write_color (framebuffer write); busy; clear_done.
// Build option: CANVAS_SCHED_CLIP_EN - when defined, stamp pixels that fall outside
//          the canvas keep write_en low (their cycles are still spent); when
//          undefined every stamp pixel is written at the low 10 bits of its address.
module canvas_write_scheduler
    import canvas_pkg::*;
#(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 380,
    parameter int PALETTE_BITS = 2,
    parameter int MAX_BRUSH    = MAX_BRUSH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_req,
    input  logic                    stamp_valid,
    output logic                    stamp_ready,
    input  logic [COORD_W-1:0]      stamp_x,
    input  logic [COORD_W-1:0]      stamp_y,
    input  logic [3:0]              stamp_size,
    input  logic [PALETTE_BITS-1:0] stamp_color,
    output logic [COORD_W-1:0]      write_x,
    output logic [COORD_W-1:0]      write_y,
    output logic                    write_en,
    output logic [PALETTE_BITS-1:0] write_color,
    output logic                    busy,
    output logic                    clear_done
);

    // The pixel address is formed one bit wider only when clipping needs to see
    // the carry; otherwise it deliberately wraps at the coordinate width.
`ifdef CANVAS_SCHED_CLIP_EN
    localparam int SUM_W = COORD_W + 1;
`else
    localparam int SUM_W = COORD_W;
`endif

    sched_state_t              state;
    sched_state_t              nextState;
    logic [COORD_W-1:0]        baseX;
    logic [COORD_W-1:0]        baseY;
    logic [PALETTE_BITS-1:0]   stampColor;
    logic [3:0]                clampedSize;
    logic                      accept;

    logic                      startClear;
    logic                      startStamp;
    logic                      stepStamp;
    logic                      stepClear;
    logic                      doneD;

    logic                      scanLoad;
    logic                      scanAdvance;
    logic [COORD_W-1:0]        scanSpanX;
    logic [COORD_W-1:0]        scanSpanY;
    logic [COORD_W-1:0]        scanNextDx;
    logic [COORD_W-1:0]        scanNextDy;
    logic                      scanLast;

    logic [COORD_W-1:0]        originX;
    logic [COORD_W-1:0]        originY;
    logic [COORD_W-1:0]        offsetX;
    logic [COORD_W-1:0]        offsetY;
    logic [SUM_W-1:0]          pixSumX;
    logic [SUM_W-1:0]          pixSumY;
    logic                      pixInside;

    logic                      wrEnD;
    logic [COORD_W-1:0]        wrXD;
    logic [COORD_W-1:0]        wrYD;
    logic [PALETTE_BITS-1:0]   wrColorD;

    assign clampedSize = clampSize(stamp_size, MAX_BRUSH);
    assign stamp_ready = rst && (state == IDLE) && !clear_req;
    assign accept      = stamp_valid && stamp_ready;
    assign busy        = (state != IDLE);

    rect_scanner #(.CW(COORD_W)) u_scanner (
        .clk     (clk),
        .rst     (rst),
        .load    (scanLoad),
        .advance (scanAdvance),
        .spanX   (scanSpanX),
        .spanY   (scanSpanY),
        .nextDx  (scanNextDx),
        .nextDy  (scanNextDy),
        .last    (scanLast)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    nextState = CLEAR;
                end else if (accept && (clampedSize != 4'd0)) begin
                    nextState = STAMP;
                end
            end
            STAMP: begin
                if (clear_req) begin
                    nextState = CLEAR;
                end else if (scanLast) begin
                    nextState = IDLE;
                end
            end
            CLEAR: begin
                if (scanLast) begin
                    nextState = clear_req ? CLEAR : IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Output logic: decides what the write registers present next cycle. The
    // scanner always tracks the pixel currently on the write outputs, so a
    // start presents (0,0) and a step presents the scanner's next position.
    always_comb begin
        startClear = 1'b0;
        startStamp = 1'b0;
        stepStamp  = 1'b0;
        stepClear  = 1'b0;
        doneD      = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    startClear = 1'b1;
                end else if (accept && (clampedSize != 4'd0)) begin
                    startStamp = 1'b1;
                end
            end
            STAMP: begin
                if (clear_req) begin
                    startClear = 1'b1;
                end else if (!scanLast) begin
                    stepStamp = 1'b1;
                end
            end
            CLEAR: begin
                if (scanLast) begin
                    doneD      = 1'b1;
                    startClear = clear_req;
                end else begin
                    stepClear = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Stamp pixel address: the first pixel comes straight from the request
    // inputs because the base registers are only loaded on that same edge.
    always_comb begin
        originX = (state == IDLE) ? stamp_x : baseX;
        originY = (state == IDLE) ? stamp_y : baseY;
        offsetX = (state == IDLE) ? '0 : scanNextDx;
        offsetY = (state == IDLE) ? '0 : scanNextDy;
        pixSumX = SUM_W'(originX) + SUM_W'(offsetX);
        pixSumY = SUM_W'(originY) + SUM_W'(offsetY);
`ifdef CANVAS_SCHED_CLIP_EN
        pixInside = (pixSumX < SUM_W'(WIDTH)) && (pixSumY < SUM_W'(HEIGHT));
`else
        pixInside = 1'b1;
`endif
    end

    always_comb begin
        scanLoad    = startClear || startStamp;
        scanAdvance = stepStamp || stepClear;
        scanSpanX   = startClear ? COORD_W'(WIDTH)  : COORD_W'(clampedSize);
        scanSpanY   = startClear ? COORD_W'(HEIGHT) : COORD_W'(clampedSize);
        wrEnD       = 1'b0;
        wrXD        = write_x;
        wrYD        = write_y;
        wrColorD    = write_color;
        if (startClear) begin
            wrEnD    = 1'b1;
            wrXD     = '0;
            wrYD     = '0;
            wrColorD = '0;
        end else if (startStamp || stepStamp) begin
            wrEnD    = pixInside;
            wrXD     = pixSumX[COORD_W-1:0];
            wrYD     = pixSumY[COORD_W-1:0];
            wrColorD = startStamp ? stamp_color : stampColor;
        end else if (stepClear) begin
            wrEnD    = 1'b1;
            wrXD     = scanNextDx;
            wrYD     = scanNextDy;
            wrColorD = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_en    <= 1'b0;
            write_x     <= '0;
            write_y     <= '0;
            write_color <= '0;
            clear_done  <= 1'b0;
            baseX       <= '0;
            baseY       <= '0;
            stampColor  <= '0;
        end else begin
            write_en    <= wrEnD;
            write_x     <= wrXD;
            write_y     <= wrYD;
            write_color <= wrColorD;
            clear_done  <= doneD;
            if (accept) begin
                baseX      <= stamp_x;
                baseY      <= stamp_y;
                stampColor <= stamp_color;
            end
        end
    end

endmodule

// File: tb/tb_canvas_write_scheduler.sv
// tb/tb_canvas_write_scheduler.sv - scoreboard bench for canvas_write_scheduler
module tb_canvas_write_scheduler;

    localparam int W  = 40;
    localparam int H  = 24;
    localparam int PB = 2;
    localparam int MB = 8;

    typedef struct packed {
        logic [9:0]    x;
        logic [9:0]    y;
        logic [PB-1:0] c;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear_req = 1'b0;
    logic          stamp_valid = 1'b0;
    logic          stamp_ready;
    logic [9:0]    stamp_x = '0;
    logic [9:0]    stamp_y = '0;
    logic [3:0]    stamp_size = '0;
    logic [PB-1:0] stamp_color = '0;
    logic [9:0]    write_x;
    logic [9:0]    write_y;
    logic          write_en;
    logic [PB-1:0] write_color;
    logic          busy;
    logic          clear_done;

    pix_t expQ[$];
    pix_t expPix;
    int   vectors = 0;
    int   miscompares = 0;
    int   doneCount = 0;

    canvas_write_scheduler #(
        .WIDTH(W), .HEIGHT(H), .PALETTE_BITS(PB), .MAX_BRUSH(MB)
    ) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .stamp_valid(stamp_valid), .stamp_ready(stamp_ready),
        .stamp_x(stamp_x), .stamp_y(stamp_y), .stamp_size(stamp_size),
        .stamp_color(stamp_color), .write_x(write_x), .write_y(write_y),
        .write_en(write_en), .write_color(write_color), .busy(busy),
        .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, required finish before it");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference model: the first cnt pixels of an n x n square in raster order.
    function automatic void pushStamp(input int x, input int y, input int n, input int col, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int   px;
            int   py;
            bit   keep;
            pix_t p;
            px   = x + (i % n);
            py   = y + (i / n);
            keep = 1'b1;
`ifdef CANVAS_SCHED_CLIP_EN
            keep = (px < W) && (py < H);
`endif
            if (keep) begin
                p.x = 10'(px);
                p.y = 10'(py);
                p.c = PB'(col);
                expQ.push_back(p);
            end
        end
    endfunction

    function automatic void pushClear(input int passes);
        for (int p = 0; p < passes; p++) begin
            for (int yy = 0; yy < H; yy++) begin
                for (int xx = 0; xx < W; xx++) begin
                    pix_t q;
                    q.x = 10'(xx);
                    q.y = 10'(yy);
                    q.c = '0;
                    expQ.push_back(q);
                end
            end
        end
    endfunction

    // Monitor: every framebuffer write is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst && write_en) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got (%0d,%0d) color %0d, required no write",
                         write_x, write_y, write_color);
            end else begin
                expPix = expQ.pop_front();
                if (write_x !== expPix.x || write_y !== expPix.y || write_color !== expPix.c) begin
                    miscompares++;
                    $display("FAIL write_pixel: got (%0d,%0d) color %0d, required (%0d,%0d) color %0d",
                             write_x, write_y, write_color, expPix.x, expPix.y, expPix.c);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (clear_done) doneCount++;
    end

    task automatic waitClearIdle(input int startDone, input int expDone);
        int t;
        t = 0;
        while (busy && t < 3 * W * H) begin
            @(negedge clk);
            t++;
        end
        #1;
        check("clear_back_to_idle", busy, 0);
        check("clear_done_pulses", doneCount - startDone, expDone);
    endtask

    task automatic doStamp(input int x, input int y, input int sz, input int col, input int abortAt);
        int n;
        int cnt;
        int cycles;
        int d0;
        bit ok;
        bit firstEn;
        n           = (sz > MB) ? MB : sz;
        stamp_x     = 10'(x);
        stamp_y     = 10'(y);
        stamp_size  = 4'(sz);
        stamp_color = PB'(col);
        stamp_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 4 * W * H; t++) begin
            #1;
            if (stamp_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("stamp_accept_wait", int'(ok), 1);
        if (!ok) begin
            stamp_valid = 1'b0;
            return;
        end
        cnt = (abortAt >= 0) ? abortAt + 1 : n * n;
        pushStamp(x, y, n, col, cnt);
        firstEn = 1'b1;
`ifdef CANVAS_SCHED_CLIP_EN
        firstEn = (x < W) && (y < H);
`endif
        @(negedge clk);
        stamp_valid = 1'b0;
        if (n == 0) begin
            check("zero_size_busy", busy, 0);
            check("zero_size_ready", stamp_ready, 1);
            return;
        end
        check("first_write_en", write_en, int'(firstEn));
        cycles = 0;
        while (busy && cycles < n * n + 4) begin
            if (cycles == abortAt) begin
                d0 = doneCount;
                pushClear(1);
                clear_req = 1'b1;
                @(negedge clk);
                clear_req = 1'b0;
                waitClearIdle(d0, 1);
                return;
            end
            cycles++;
            @(negedge clk);
        end
        check("stamp_busy_cycles", cycles, n * n);
        check("ready_after_stamp", stamp_ready, 1);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("reset_write_en", write_en, 0);
        check("reset_busy", busy, 0);
        check("reset_clear_done", clear_done, 0);
        check("reset_write_x", write_x, 0);
        check("reset_write_y", write_y, 0);
        check("reset_write_color", write_color, 0);
        check("reset_stamp_ready", stamp_ready, 0);
        rst = 1'b1;
        #1;
        check("ready_after_release", stamp_ready, 1);
        @(negedge clk);

        doStamp(10, 20, 2, 3, -1);
        doStamp(W - 2, H - 1, 4, 1, -1);
        doStamp(5, 3, 12, 2, -1);
        doStamp(7, 9, 0, 1, -1);
        doStamp(2, 2, 4, 1, 3);

        // clear_req and stamp_valid rise together: the clear wins
        @(negedge clk);
        d0          = doneCount;
        stamp_x     = 10'd3;
        stamp_y     = 10'd4;
        stamp_size  = 4'd3;
        stamp_color = 2'd2;
        stamp_valid = 1'b1;
        clear_req   = 1'b1;
        pushClear(1);
        #1;
        check("ready_low_with_clear", stamp_ready, 0);
        @(negedge clk);
        clear_req = 1'b0;
        check("busy_in_clear", busy, 1);
        check("ready_low_in_clear", stamp_ready, 0);
        doStamp(3, 4, 3, 2, -1);
        check("clear_done_before_stamp", doneCount - d0, 1);

        // clear_req held past the end of a pass restarts the scan
        @(negedge clk);
        d0        = doneCount;
        clear_req = 1'b1;
        pushClear(2);
        repeat (W * H + W) @(negedge clk);
        check("ready_low_held_clear", stamp_ready, 0);
        clear_req = 1'b0;
        waitClearIdle(d0, 2);

        // reset in the middle of a clear
        @(negedge clk);
        clear_req = 1'b1;
        pushClear(1);
        @(negedge clk);
        clear_req = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b0;
        #1;
        expQ.delete();
        check("midreset_write_en", write_en, 0);
        check("midreset_busy", busy, 0);
        check("midreset_write_x", write_x, 0);
        check("midreset_stamp_ready", stamp_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_ready_after", stamp_ready, 1);
        repeat (20) @(negedge clk);
        check("midreset_stays_idle", busy, 0);

        for (int i = 0; i < 25; i++) begin
            int x;
            int y;
            int sz;
            int col;
            int n;
            int ab;
            x   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, W + 4));
            y   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, H + 4));
            sz  = int'($urandom_range(0, 15));
            col = int'($urandom_range(0, 3));
            n   = (sz > MB) ? MB : sz;
            ab  = -1;
            if (n > 0 && $urandom_range(0, 5) == 0) ab = int'($urandom_range(0, n * n - 1));
            doStamp(x, y, sz, col, ab);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
